// File: rtl/multi_mul_seq_if.sv
// Handshake bundle for the sequential multiplier.
// start/a/b in; busy/done/p out.
interface multi_mul_seq_if #(
  parameter int S = 3
);
  localparam int N = 1 << S;

  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/multi_mul_seq.sv
// Shift-and-add unsigned multiplier, one adder, one bit per cycle.
// Ports: clk, rst_n (async low), bus (start/a/b -> busy/done/p).
module multi_add #(
  parameter int S = 3
) (
  input  logic [(1<<S)-1:0] a,
  input  logic [(1<<S)-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic [(1<<S)-1:0] sum,
  output logic              cout
);
  localparam int N = 1 << S;

  logic [N-1:0] bx;
  logic [N:0]   res;

  assign bx  = sub ? ~b : b;
  assign res = {1'b0, a} + {1'b0, bx}
             + {{N{1'b0}}, cin ^ sub};
  assign sum  = res[N-1:0];
  assign cout = res[N];
endmodule

module multi_mul_seq #(
  parameter int S = 3
) (
  input logic             clk,
  input logic             rst_n,
  multi_mul_seq_if.slave  bus
);
  localparam int N = 1 << S;
  localparam logic [S-1:0] CNT_LAST = S'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   mcand;
  logic [2*N-1:0] acc;
  logic [S-1:0]   cnt;
  logic [2*N-1:0] p_q;

  logic [N-1:0]   add_b;
  logic [N-1:0]   sum;
  logic           cout;
  logic [2*N-1:0] acc_nxt;

  assign add_b = acc[0] ? mcand : '0;

  multi_add #(.S(S)) u_add (
    .a    (acc[2*N-1:N]),
    .b    (add_b),
    .cin  (1'b0),
    .sub  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Carry lands in the top bit so the 2N+1 bit
  // partial result survives the shift.
  assign acc_nxt = {cout, sum, acc[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      p_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.a;
            acc   <= {{N{1'b0}}, bus.b};
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            p_q   <= acc_nxt;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.p    = p_q;
endmodule

// File: tb/tb_multi_mul_seq.sv
// Bench: S=3 and S=2 multipliers against a
// cycle-count model plus literal checks.
module tb_multi_mul_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  multi_mul_seq_if #(.S(3)) bus3 ();
  multi_mul_seq_if #(.S(2)) bus2 ();

  multi_mul_seq #(.S(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  multi_mul_seq #(.S(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int asserts = 0;
  int fails = 0;

  // Model: after an accept the unit stays busy for
  // N+1 cycles; the last of them is the done cycle,
  // and the product appears when it begins.
  int rem3 = 0, pend3 = 0, ep3 = 0;
  int rem2 = 0, pend2 = 0, ep2 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem3 = 0; ep3 = 0;
      rem2 = 0; ep2 = 0;
    end else begin
      if (rem3 == 0) begin
        if (bus3.start) begin
          pend3 = int'(bus3.a) * int'(bus3.b);
          rem3 = 8 + 1;
        end
      end else begin
        rem3 = rem3 - 1;
        if (rem3 == 1) ep3 = pend3;
      end
      if (rem2 == 0) begin
        if (bus2.start) begin
          pend2 = int'(bus2.a) * int'(bus2.b);
          rem2 = 4 + 1;
        end
      end else begin
        rem2 = rem2 - 1;
        if (rem2 == 1) ep2 = pend2;
      end
    end
  end

  task automatic check(input string name,
                       input int act,
                       input int exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic op3(input int x, input int y,
                     input int lit);
    int got;
    got = -1;
    bus3.a = 8'(x);
    bus3.b = 8'(y);
    bus3.start = 1'b1;
    @(posedge clk);
    #1 bus3.start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus3.done) begin
        got = i;
        break;
      end
    end
    check("lat3", got, 8);
    check("p3", int'(bus3.p), lit);
    @(posedge clk);
    #1;
  endtask

  task automatic op2(input int x, input int y);
    int got;
    got = -1;
    bus2.a = 4'(x);
    bus2.b = 4'(y);
    bus2.start = 1'b1;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus2.done) begin
        got = i;
        break;
      end
    end
    check("lat2", got, 4);
    check("p2", int'(bus2.p), x * y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;

    fork
      forever begin
        @(negedge clk);
        check("busy3", int'(bus3.busy), int'(rem3 != 0));
        check("done3", int'(bus3.done), int'(rem3 == 1));
        check("pm3", int'(bus3.p), ep3);
        check("busy2", int'(bus2.busy), int'(rem2 != 0));
        check("done2", int'(bus2.done), int'(rem2 == 1));
        check("pm2", int'(bus2.p), ep2);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus3.busy), 0);
    check("rst_p", int'(bus3.p), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op3(3, 5, 15);
    op3(255, 255, 65025);
    op3(0, 200, 0);
    op3(200, 0, 0);
    repeat (3) @(posedge clk);
    #1 check("p_hold0", int'(bus3.p), 0);

    // start held high: operands change during done
    bus3.a = 8'd7; bus3.b = 8'd9; bus3.start = 1'b1;
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus3.done) begin
        edges = i;
        break;
      end
    end
    check("bb_p1", int'(bus3.p), 63);
    bus3.a = 8'd12; bus3.b = 8'd12;
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus3.done) begin
        edges = i;
        break;
      end
    end
    check("bb_period", edges, 10);
    check("bb_p2", int'(bus3.p), 144);
    bus3.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // abort mid-run with an async reset
    bus3.a = 8'd100; bus3.b = 8'd3; bus3.start = 1'b1;
    @(posedge clk);
    #1 bus3.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(bus3.busy), 0);
    check("abort_done", int'(bus3.done), 0);
    check("abort_p", int'(bus3.p), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1 check("abort_nodone", int'(bus3.done), 0);
    end
    op3(100, 3, 300);

    for (int k = 0; k < 40; k++) begin
      int x, y;
      x = int'($urandom_range(255, 0));
      y = int'($urandom_range(255, 0));
      op3(x, y, x * y);
    end

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op2(x, y);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end
endmodule
